// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM stage: data-memory req/ack control, load align/extend, MEM/WB register
module mem_stage_ctrl #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MEM_ALU_out,
    input  logic [31:0] MEM_memory_in,
    input  logic [31:0] MEM_MemWrite,
    input  logic        MEM_MemRead,
    input  logic [2:0]  MEM_funct3,
    input  logic [31:0] MEM_pc,
    input  logic        MEM_RDSrc,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_RegWrite,
    input  logic        MEM_f_RegWrite,
    input  logic [4:0]  MEM_write_addr,
    input  logic [4:0]  MEM_f_write_addr,
    output logic        dm_req,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wmask,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stall,
    output logic        mem_err,
    output logic [31:0] WB_rd_data,
    output logic [4:0]  WB_write_addr,
    output logic [4:0]  WB_f_write_addr,
    output logic        WB_RegWrite,
    output logic        WB_f_RegWrite
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic          err_q, err_d;

    logic [31:0]   wb_data_q, wb_data_d;
    logic [4:0]    wb_addr_q, wb_addr_d;
    logic [4:0]    wb_faddr_q, wb_faddr_d;
    logic          wb_rw_q, wb_rw_d;
    logic          wb_frw_q, wb_frw_d;

    logic          access;
    logic          timeout;
    logic [31:0]   rword;
    logic [31:0]   byte_shift;
    logic [31:0]   half_shift;
    logic [31:0]   load_val;

    // Request/stall decode; armed gating blocks the all-zero mask seen right after reset
    always_comb begin
        access   = armed_q & (MEM_MemRead | (MEM_MemWrite != 32'hFFFF_FFFF));
        timeout  = (state_q == S_BUSY) & (cnt_q == CNT_MAX) & ~dm_ack;
        dm_req   = access;
        dm_addr  = {MEM_ALU_out[31:2], 2'b00};
        dm_wmask = access ? MEM_MemWrite : 32'hFFFF_FFFF;
        dm_wdata = MEM_memory_in;
        stall    = access & ~dm_ack & ~timeout;
    end

    // Access tracking FSM: wait counter and sticky timeout error
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        armed_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (access && !dm_ack) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_ONE;
                end
            end
            default: begin
                if (dm_ack) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // Load lane select and extension; a timed-out read returns zero
    always_comb begin
        rword      = timeout ? 32'h0 : dm_rdata;
        byte_shift = rword >> {MEM_ALU_out[1:0], 3'b000};
        half_shift = rword >> {MEM_ALU_out[1], 4'b0000};
        case (MEM_funct3)
            3'b000:  load_val = {{24{byte_shift[7]}}, byte_shift[7:0]};
            3'b001:  load_val = {{16{half_shift[15]}}, half_shift[15:0]};
            3'b100:  load_val = {24'h0, byte_shift[7:0]};
            3'b101:  load_val = {16'h0, half_shift[15:0]};
            default: load_val = rword;
        endcase
    end

    // MEM/WB register next value: bubble the write enables while stalled
    always_comb begin
        wb_data_d  = wb_data_q;
        wb_addr_d  = wb_addr_q;
        wb_faddr_d = wb_faddr_q;
        wb_rw_d    = 1'b0;
        wb_frw_d   = 1'b0;
        if (!stall) begin
            if (MEM_MemtoReg) begin
                wb_data_d = load_val;
            end else if (MEM_RDSrc) begin
                wb_data_d = MEM_pc + 32'd4;
            end else begin
                wb_data_d = MEM_ALU_out;
            end
            wb_addr_d  = MEM_write_addr;
            wb_faddr_d = MEM_f_write_addr;
            wb_rw_d    = MEM_RegWrite;
            wb_frw_d   = MEM_f_RegWrite;
        end
    end

    // State and pipeline registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            err_q      <= 1'b0;
            wb_data_q  <= 32'h0;
            wb_addr_q  <= 5'h0;
            wb_faddr_q <= 5'h0;
            wb_rw_q    <= 1'b0;
            wb_frw_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            err_q      <= err_d;
            wb_data_q  <= wb_data_d;
            wb_addr_q  <= wb_addr_d;
            wb_faddr_q <= wb_faddr_d;
            wb_rw_q    <= wb_rw_d;
            wb_frw_q   <= wb_frw_d;
        end
    end

    assign mem_err         = err_q;
    assign WB_rd_data      = wb_data_q;
    assign WB_write_addr   = wb_addr_q;
    assign WB_f_write_addr = wb_faddr_q;
    assign WB_RegWrite     = wb_rw_q;
    assign WB_f_RegWrite   = wb_frw_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - randomized self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

    localparam int MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu, mem_in, memwrite, pc, dm_rdata;
    logic        memread, rdsrc, m2r, rw, frw, dm_ack;
    logic [2:0]  f3;
    logic [4:0]  wa, fwa;
    logic        dm_req, stall, mem_err;
    logic [31:0] dm_addr, dm_wmask, dm_wdata, WB_rd_data;
    logic [4:0]  WB_write_addr, WB_f_write_addr;
    logic        WB_RegWrite, WB_f_RegWrite;

    int n_checks = 0;
    int n_errors = 0;
    logic err_m = 1'b0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .MEM_ALU_out(alu), .MEM_memory_in(mem_in), .MEM_MemWrite(memwrite),
        .MEM_MemRead(memread), .MEM_funct3(f3), .MEM_pc(pc),
        .MEM_RDSrc(rdsrc), .MEM_MemtoReg(m2r),
        .MEM_RegWrite(rw), .MEM_f_RegWrite(frw),
        .MEM_write_addr(wa), .MEM_f_write_addr(fwa),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_wmask(dm_wmask), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .stall(stall), .mem_err(mem_err),
        .WB_rd_data(WB_rd_data), .WB_write_addr(WB_write_addr),
        .WB_f_write_addr(WB_f_write_addr),
        .WB_RegWrite(WB_RegWrite), .WB_f_RegWrite(WB_f_RegWrite)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference load extraction from plain arithmetic on the word
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] b,
                                             input logic [2:0] fn);
        int unsigned wu, byt, half;
        wu   = w;
        byt  = (wu / (32'd1 << (8 * b))) % 256;
        half = (wu / (32'd1 << (16 * (b / 2)))) % 65536;
        case (fn)
            3'd0:    return (byt >= 128) ? byt - 256 : byt;
            3'd1:    return (half >= 32768) ? half - 65536 : half;
            3'd4:    return byt;
            3'd5:    return half;
            default: return w;
        endcase
    endfunction

    // Present one instruction, answer the memory after d cycles, check stall/bus/WB
    task automatic run_instr(input logic [31:0] a, wd, mask, input logic rd,
                             input logic [2:0] fn, input logic [31:0] p,
                             input logic rs, mr, r_w, fr_w, input logic [4:0] ad, fad,
                             input logic [31:0] rdata, input int d);
        logic acc, to, done;
        int nst;
        logic [31:0] w, exp_wb;
        acc = rd || (mask != 32'hFFFF_FFFF);
        nst = !acc ? 0 : (d > MAX_WAIT ? MAX_WAIT : d);
        to  = acc && (d > MAX_WAIT);
        alu = a; mem_in = wd; memwrite = mask; memread = rd; f3 = fn; pc = p;
        rdsrc = rs; m2r = mr; rw = r_w; frw = fr_w; wa = ad; fwa = fad;
        done = 1'b0;
        for (int c = 0; c <= MAX_WAIT + 1 && !done; c++) begin
            dm_ack   = acc ? (c == d) : 1'($urandom_range(0, 1));
            dm_rdata = (!acc || c == d) ? rdata : $urandom;
            @(negedge clk);
            check_eq("stall", stall, (c < nst));
            check_eq("dm_req", dm_req, acc);
            check_eq("dm_wmask", dm_wmask, acc ? mask : 32'hFFFF_FFFF);
            if (acc) begin
                check_eq("dm_addr", dm_addr, a & 32'hFFFF_FFFC);
                check_eq("dm_wdata", dm_wdata, wd);
            end
            @(posedge clk);
            #1;
            if (c >= nst) begin
                if (to) err_m = 1'b1;
                w = to ? 32'h0 : rdata;
                exp_wb = mr ? ref_load(w, a[1:0], fn) : (rs ? p + 32'd4 : a);
                check_eq("wb_data", WB_rd_data, exp_wb);
                check_eq("wb_rw", WB_RegWrite, r_w);
                check_eq("wb_frw", WB_f_RegWrite, fr_w);
                check_eq("wb_addr", WB_write_addr, ad);
                check_eq("wb_faddr", WB_f_write_addr, fad);
                check_eq("mem_err", mem_err, err_m);
                done = 1'b1;
            end else begin
                check_eq("bubble_rw", WB_RegWrite, 1'b0);
                check_eq("bubble_frw", WB_f_RegWrite, 1'b0);
            end
        end
        check_eq("instr_done", done, 1'b1);
    endtask

    // Release reset mid-cycle; the first cycle must not issue even with a live request
    task automatic release_and_arm();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("unarmed_req", dm_req, 1'b0);
        check_eq("unarmed_stall", stall, 1'b0);
        check_eq("unarmed_wmask", dm_wmask, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        memwrite = 32'hFFFF_FFFF; memread = 1'b0; rw = 1'b1; m2r = 1'b0; rdsrc = 1'b0;
        @(negedge clk);
        check_eq("idle_req", dm_req, 1'b0);
        @(posedge clk);
        #1;
        check_eq("idle_wb_rw", WB_RegWrite, 1'b1);
    endtask

    initial begin
        logic [31:0] a, mask, word;
        logic [2:0] fn;
        int kind, sz;
        reset = 1'b1; alu = 32'h0; mem_in = 32'h0; memwrite = 32'h0; memread = 1'b0;
        f3 = 3'd0; pc = 32'h0; rdsrc = 1'b0; m2r = 1'b0; rw = 1'b0; frw = 1'b0;
        wa = 5'd0; fwa = 5'd0; dm_rdata = 32'h0; dm_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_wb_data", WB_rd_data, 32'h0);
        check_eq("rst_wb_rw", WB_RegWrite, 1'b0);
        check_eq("rst_wb_frw", WB_f_RegWrite, 1'b0);
        check_eq("rst_wb_addr", WB_write_addr, 5'd0);
        check_eq("rst_mem_err", mem_err, 1'b0);
        release_and_arm();

        // LB with two-cycle ack
        run_instr(32'h103, 32'h0, 32'hFFFF_FFFF, 1'b1, 3'd0, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0,
                  5'd3, 5'd0, 32'h80FF_1234, 2);
        check_eq("lb_val", WB_rd_data, 32'hFFFF_FF80);
        // LHU with zero-wait ack
        run_instr(32'h102, 32'h0, 32'hFFFF_FFFF, 1'b1, 3'd5, 32'h44, 1'b0, 1'b1, 1'b1, 1'b0,
                  5'd4, 5'd0, 32'h8001_AAAA, 0);
        check_eq("lhu_val", WB_rd_data, 32'h0000_8001);
        // SB with one-cycle ack
        run_instr(32'h201, 32'h0000_5A00, 32'hFFFF_00FF, 1'b0, 3'd0, 32'h48, 1'b0, 1'b0, 1'b0,
                  1'b0, 5'd0, 5'd0, 32'h0, 1);
        // JAL at top of address space wraps
        run_instr(32'h1234, 32'h0, 32'hFFFF_FFFF, 1'b0, 3'd0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1,
                  1'b0, 5'd1, 5'd0, 32'h0, 0);
        check_eq("jal_wrap", WB_rd_data, 32'h0);
        // MemtoReg beats RDSrc
        run_instr(32'h300, 32'h0, 32'hFFFF_FFFF, 1'b1, 3'd2, 32'h50, 1'b1, 1'b1, 1'b1, 1'b0,
                  5'd5, 5'd0, 32'hDEAD_BEEF, 0);
        check_eq("m2r_prio", WB_rd_data, 32'hDEAD_BEEF);
        // Ack on the last allowed cycle: no error
        run_instr(32'h304, 32'h0, 32'hFFFF_FFFF, 1'b1, 3'd2, 32'h54, 1'b0, 1'b1, 1'b1, 1'b0,
                  5'd6, 5'd0, 32'h1357_9BDF, MAX_WAIT);
        check_eq("edge_no_err", mem_err, 1'b0);
        // No ack at all: timeout
        run_instr(32'h308, 32'h0, 32'hFFFF_FFFF, 1'b1, 3'd2, 32'h58, 1'b0, 1'b1, 1'b1, 1'b0,
                  5'd7, 5'd0, 32'hFFFF_FFFF, 99);
        check_eq("to_err", mem_err, 1'b1);
        check_eq("to_data", WB_rd_data, 32'h0);

        // Randomized mix of loads, stores and ALU ops
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            a    = $urandom;
            word = $urandom;
            fn   = 3'($urandom_range(0, 7));
            mask = 32'hFFFF_FFFF;
            if (kind >= 4 && kind <= 6) begin
                sz = $urandom_range(0, 2);
                if (sz == 0)      mask = ~(32'hFF << (8 * a[1:0]));
                else if (sz == 1) mask = ~(32'hFFFF << (16 * a[1]));
                else              mask = 32'h0;
            end
            run_instr(a, $urandom, mask, (kind <= 3), fn, $urandom,
                      1'($urandom_range(0, 1)), (kind <= 3) ? 1'($urandom_range(0, 4) != 0) : 1'b0,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      5'($urandom), 5'($urandom), word, $urandom_range(0, MAX_WAIT + 2));
        end

        // Reset in the middle of an outstanding load
        alu = 32'h400; memwrite = 32'hFFFF_FFFF; memread = 1'b1; m2r = 1'b1; rw = 1'b1;
        dm_ack = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("pre_rst_stall", stall, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_req", dm_req, 1'b0);
        check_eq("mid_rst_err", mem_err, 1'b0);
        check_eq("mid_rst_stall", stall, 1'b0);
        check_eq("mid_rst_rw", WB_RegWrite, 1'b0);
        err_m = 1'b0;
        release_and_arm();
        run_instr(32'h501, 32'h0, 32'hFFFF_FFFF, 1'b1, 3'd4, 32'h60, 1'b0, 1'b1, 1'b1, 1'b1,
                  5'd9, 5'd10, 32'h0000_C300, 3);
        check_eq("post_rst_lbu", WB_rd_data, 32'h0000_00C3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
